// File: rtl/snoop_responder.sv
// Snoop side of an MSI coherence controller: watches bus messages, updates the local
// line state array, and raises hit/abort/error pulses plus a held writeback request.
module snoop_responder #(
  parameter int unsigned NUM_LINHAS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic [1:0]       bus_msg,
  input  logic [IDX_W-1:0] bus_idx,
  input  logic [TAG_W-1:0] bus_tag,
  input  logic             cpu_we,
  input  logic [IDX_W-1:0] cpu_idx,
  input  logic [TAG_W-1:0] cpu_tag,
  input  logic [1:0]       cpu_estado,
  output logic             snoop_hit,
  output logic             abort_mem,
  output logic             erro,
  output logic             colisao,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_idx,
  output logic [TAG_W-1:0] wb_tag,
  input  logic [IDX_W-1:0] consulta_idx,
  output logic [1:0]       consulta_estado
);

  localparam logic [1:0] EstInv  = 2'b00;
  localparam logic [1:0] EstSh   = 2'b01;
  localparam logic [1:0] EstEx   = 2'b10;
  localparam logic [1:0] MsgRd   = 2'b00;
  localparam logic [1:0] MsgInv  = 2'b01;
  localparam logic [1:0] MsgNull = 2'b11;

  typedef enum logic [1:0] {StIdle, StLookup, StWb} state_t;

  state_t state_q, state_d;

  logic [NUM_LINHAS-1:0][1:0]       estado_q, estado_d;
  logic [NUM_LINHAS-1:0][TAG_W-1:0] tag_q, tag_d;

  logic [1:0]       cap_msg_q, cap_msg_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [TAG_W-1:0] cap_tag_q, cap_tag_d;

  logic snoop_hit_q, snoop_hit_d;
  logic abort_q, abort_d;
  logic erro_q, erro_d;
  logic colisao_q, colisao_d;
  logic wb_valid_q, wb_valid_d;
  // High for the cycle right after LOOKUP so bus_ready stays low one extra cycle.
  logic resp_q;

  logic [1:0] cur_estado;
  logic       hit;
  logic       excl;
  logic       clash;
  logic       wb_req;

  assign cur_estado = estado_q[cap_idx_q];
  assign excl       = (cur_estado == EstEx);
  assign hit        = (tag_q[cap_idx_q] == cap_tag_q) && ((cur_estado == EstSh) || excl);
  assign clash      = (state_q == StLookup) && cpu_we && (cpu_idx == cap_idx_q);

  assign bus_ready       = (state_q == StIdle) && !resp_q;
  assign snoop_hit       = snoop_hit_q;
  assign abort_mem       = abort_q;
  assign erro            = erro_q;
  assign colisao         = colisao_q;
  assign wb_valid        = wb_valid_q;
  assign wb_idx          = cap_idx_q;
  assign wb_tag          = cap_tag_q;
  assign consulta_estado = estado_q[consulta_idx];

  always_comb begin
    state_d     = state_q;
    estado_d    = estado_q;
    tag_d       = tag_q;
    cap_msg_d   = cap_msg_q;
    cap_idx_d   = cap_idx_q;
    cap_tag_d   = cap_tag_q;
    snoop_hit_d = 1'b0;
    abort_d     = 1'b0;
    erro_d      = 1'b0;
    colisao_d   = 1'b0;
    wb_valid_d  = wb_valid_q;
    wb_req      = 1'b0;

    if (cpu_we && !clash) begin
      estado_d[cpu_idx] = (cpu_estado == 2'b11) ? EstInv : cpu_estado;
      tag_d[cpu_idx]    = cpu_tag;
    end

    unique case (state_q)
      StIdle: begin
        if (bus_valid && bus_ready) begin
          cap_msg_d = bus_msg;
          cap_idx_d = bus_idx;
          cap_tag_d = bus_tag;
          state_d   = StLookup;
        end
      end
      StLookup: begin
        state_d   = StIdle;
        colisao_d = clash;
        if (hit && (cap_msg_q != MsgNull)) begin
          snoop_hit_d = 1'b1;
          case (cap_msg_q)
            MsgRd: begin
              estado_d[cap_idx_q] = EstSh;
              wb_req              = excl;
            end
            MsgInv: begin
              estado_d[cap_idx_q] = EstInv;
              erro_d              = excl;
            end
            default: begin
              estado_d[cap_idx_q] = EstInv;
              wb_req              = excl;
            end
          endcase
          if (wb_req) begin
            abort_d    = 1'b1;
            wb_valid_d = 1'b1;
            state_d    = StWb;
          end
        end
      end
      StWb: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      estado_q    <= '0;
      tag_q       <= '0;
      cap_msg_q   <= '0;
      cap_idx_q   <= '0;
      cap_tag_q   <= '0;
      snoop_hit_q <= 1'b0;
      abort_q     <= 1'b0;
      erro_q      <= 1'b0;
      colisao_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      resp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      estado_q    <= estado_d;
      tag_q       <= tag_d;
      cap_msg_q   <= cap_msg_d;
      cap_idx_q   <= cap_idx_d;
      cap_tag_q   <= cap_tag_d;
      snoop_hit_q <= snoop_hit_d;
      abort_q     <= abort_d;
      erro_q      <= erro_d;
      colisao_q   <= colisao_d;
      wb_valid_q  <= wb_valid_d;
      resp_q      <= (state_q == StLookup);
    end
  end

endmodule
